// File: rtl/mem_access_unit.sv
// Load/store lane unit for the MEM stage: aligns store data and byte enables onto
// the bus, splits or rejects word-crossing accesses, and returns extended load data.
module mem_access_unit #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int SPLIT_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW/8-1:0] bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int MW = 2 * NB;
  localparam bit NO_SPLIT = (SPLIT_EN == 0);
  localparam bit NO_DWORD = (DW == 32);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   base_reg;
  logic [OW-1:0]   off_reg;
  logic [1:0]      size_reg;
  logic            we_reg, signed_reg, err_reg, cross_reg;
  logic [MW-1:0]   mask_reg;
  logic [2*DW-1:0] wdata_reg, buf_reg;

  logic [OW-1:0]   req_off;
  logic [3:0]      req_bytes;
  logic [16:0]     req_ones;
  logic            req_cross, req_err;
  logic [MW-1:0]   req_mask;
  logic [2*DW-1:0] req_wide;

  // Request decode: mask and data are formed two bus words wide so the spill
  // into the second beat falls out of the upper half.
  always_comb begin
    req_off   = req_addr[OW-1:0];
    req_bytes = 4'd1 << req_size;
    req_cross = (5'(req_off) + 5'(req_bytes)) > 5'(NB);
    req_ones  = (17'd1 << req_bytes) - 17'd1;
    req_mask  = MW'(req_ones) << req_off;
    req_wide  = {{DW{1'b0}}, req_wdata} << {req_off, 3'b000};
    req_err   = (NO_DWORD && (req_size == 2'd3)) || (NO_SPLIT && req_cross);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      base_reg   <= '0;
      off_reg    <= '0;
      size_reg   <= '0;
      we_reg     <= 1'b0;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      cross_reg  <= 1'b0;
      mask_reg   <= '0;
      wdata_reg  <= '0;
      buf_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        base_reg   <= {req_addr[AW-1:OW], {OW{1'b0}}};
        off_reg    <= req_off;
        size_reg   <= req_size;
        we_reg     <= req_we;
        signed_reg <= req_signed;
        err_reg    <= req_err;
        cross_reg  <= req_cross;
        mask_reg   <= req_mask;
        wdata_reg  <= req_wide;
        buf_reg    <= '0;
      end
      if (state_reg == BEAT0 && bus_ready) buf_reg[DW-1:0]    <= bus_rdata;
      if (state_reg == BEAT1 && bus_ready) buf_reg[2*DW-1:DW] <= bus_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_err ? RESP : BEAT0;
      BEAT0:   if (bus_ready) state_next = cross_reg ? BEAT1 : RESP;
      BEAT1:   if (bus_ready) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    if (state_reg == BEAT0) begin
      bus_valid = 1'b1;
      bus_we    = we_reg;
      bus_addr  = base_reg;
      bus_be    = mask_reg[NB-1:0];
      bus_wdata = wdata_reg[DW-1:0];
    end else if (state_reg == BEAT1) begin
      bus_valid = 1'b1;
      bus_we    = we_reg;
      bus_addr  = base_reg + AW'(NB);
      bus_be    = mask_reg[MW-1:NB];
      bus_wdata = wdata_reg[2*DW-1:DW];
    end
  end

  logic [2*DW-1:0] shifted;
  logic [DW-1:0]   low, ext;
  logic            sign;
  int              nbits;

  // Bits above the access width are filled with the sign (or zero); a full-width
  // access keeps every bit of the buffer so it passes through unchanged.
  always_comb begin
    shifted = buf_reg >> {off_reg, 3'b000};
    low     = shifted[DW-1:0];
    nbits   = 8 << size_reg;
    case (size_reg)
      2'd0:    sign = low[7];
      2'd1:    sign = low[15];
      default: sign = low[31];
    endcase
    for (int i = 0; i < DW; i++)
      ext[i] = (i < nbits) ? low[i] : (signed_reg & sign);
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = (state_reg == RESP) && err_reg;
  assign rsp_rdata = ((state_reg == RESP) && !we_reg && !err_reg) ? ext : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DW=32): split and non-split instances,
// bus beats and responses checked by independent negedge monitors.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid0, req_valid1;
  logic        req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  logic        req_ready0, bus_valid0, bus_we0, rsp_valid0, rsp_err0;
  logic [31:0] bus_addr0, bus_wdata0, rsp_rdata0;
  logic [3:0]  bus_be0;
  logic        req_ready1, bus_valid1, bus_we1, rsp_valid1, rsp_err1;
  logic [31:0] bus_addr1, bus_wdata1, rsp_rdata1;
  logic [3:0]  bus_be1;

  always #5 clk = ~clk;

  mem_access_unit #(.DW(32), .AW(32), .SPLIT_EN(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .bus_valid(bus_valid0),
    .bus_ready(bus_ready), .bus_we(bus_we0), .bus_addr(bus_addr0),
    .bus_be(bus_be0), .bus_wdata(bus_wdata0), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

  mem_access_unit #(.DW(32), .AW(32), .SPLIT_EN(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .bus_valid(bus_valid1),
    .bus_ready(bus_ready), .bus_we(bus_we1), .bus_addr(bus_addr1),
    .bus_be(bus_be1), .bus_wdata(bus_wdata1), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  rsp_t        exp0[$], exp1[$];
  int          cyc = 0;
  int          stall_cnt = 0;
  int          checks_total = 0;
  int          checks_pass = 0;
  logic        bus1_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks_total++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Bus slave and beat checker: drives ready/rdata for the coming edge
  always @(negedge clk) begin
    if (bus_valid1) bus1_seen = 1'b1;
    if (bus_valid0 && !rst) begin
      if (beat_q.size() == 0) begin
        fail_now("beat_unexpected");
      end else begin
        chk("beat", {bus_we0, bus_addr0, bus_be0, bus_wdata0}, beat_q[0]);
        if (stall_cnt > 0) begin
          bus_ready = 1'b0;
          stall_cnt--;
        end else begin
          bus_ready = 1'b1;
          bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
          void'(beat_q.pop_front());
        end
      end
    end
  end

  // Response monitors
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid0) begin
      if (exp0.size() == 0) fail_now("rsp0_unexpected");
      else begin
        e = exp0.pop_front();
        chk("rsp0_err", rsp_err0, e.err);
        chk("rsp0_rdata", rsp_rdata0, e.rdata);
        chk("rsp0_cycle", cyc, e.cyc);
        $display("dut0 rsp err=%0d rdata=%08h cyc=%0d", rsp_err0, rsp_rdata0, cyc);
      end
    end
    if (rsp_valid1) begin
      if (exp1.size() == 0) fail_now("rsp1_unexpected");
      else begin
        e = exp1.pop_front();
        chk("rsp1_err", rsp_err1, e.err);
        chk("rsp1_rdata", rsp_rdata1, e.rdata);
        chk("rsp1_cycle", cyc, e.cyc);
        $display("dut1 rsp err=%0d rdata=%08h cyc=%0d", rsp_err1, rsp_rdata1, cyc);
      end
    end
  end

  task automatic issue(input int which, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic push_rsp, input logic e_err, input logic [31:0] e_rdata,
                       input int lat);
    rsp_t e;
    e.err = e_err; e.rdata = e_rdata; e.cyc = cyc + lat;
    if (push_rsp) begin
      if (which == 0) exp0.push_back(e);
      else exp1.push_back(e);
    end
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    if (which == 0) req_valid0 = 1'b1;
    else req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (exp0.size() == 0 && exp1.size() == 0 && beat_q.size() == 0) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) fail_now({name, "_timeout"});
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    rst = 1'b1; req_valid0 = 0; req_valid1 = 0; req_we = 0; req_size = 0;
    req_signed = 0; req_addr = 0; req_wdata = 0; bus_ready = 1'b1; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready0, 1'b1);
    chk("reset_bus_valid", bus_valid0, 1'b0);
    chk("reset_rsp", {rsp_valid0, rsp_err0, rsp_rdata0}, 34'h0);
    chk("reset_bus_out", {bus_addr0, bus_be0, bus_wdata0}, 68'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // sb 0x1003
    beat_q.push_back('{1'b1, 32'h1003 & ~32'h3, 4'b1000, 32'hAB000000});
    rd_q.push_back(32'h12345678);
    issue(0, 1, 2'd0, 0, 32'h1003, 32'h000000AB, 1, 0, 32'h0, 2);
    chk("req_ready_busy", req_ready0, 1'b0);
    wait_done("sb");

    // lh signed / lhu at 0x2002
    beat_q.push_back('{1'b0, 32'h2000, 4'b1100, 32'h0});
    rd_q.push_back(32'h80011234);
    issue(0, 0, 2'd1, 1, 32'h2002, 32'h0, 1, 0, 32'hFFFF8001, 2);
    wait_done("lh");
    beat_q.push_back('{1'b0, 32'h2000, 4'b1100, 32'h0});
    rd_q.push_back(32'h80011234);
    issue(0, 0, 2'd1, 0, 32'h2002, 32'h0, 1, 0, 32'h00008001, 2);
    wait_done("lhu");

    // split lw 0x3003
    beat_q.push_back('{1'b0, 32'h3000, 4'b1000, 32'h0});
    beat_q.push_back('{1'b0, 32'h3004, 4'b0111, 32'h0});
    rd_q.push_back(32'hDD000000);
    rd_q.push_back(32'h00CCBBAA);
    issue(0, 0, 2'd2, 0, 32'h3003, 32'h0, 1, 0, 32'hCCBBAADD, 3);
    wait_done("lw_split");

    // non-split instance: crossing and dword both rejected, no bus activity
    issue(1, 0, 2'd2, 0, 32'h3003, 32'h0, 1, 1, 32'h0, 1);
    wait_done("lw_err");
    issue(1, 0, 2'd3, 0, 32'h3000, 32'h0, 1, 1, 32'h0, 1);
    wait_done("dw_err1");
    issue(0, 1, 2'd3, 0, 32'h3000, 32'h55, 1, 1, 32'h0, 1);
    wait_done("dw_err0");

    // in-word misaligned half, signed byte
    beat_q.push_back('{1'b0, 32'h5000, 4'b0110, 32'h0});
    rd_q.push_back(32'h00BEEF00);
    issue(0, 0, 2'd1, 0, 32'h5001, 32'h0, 1, 0, 32'h0000BEEF, 2);
    wait_done("lhu_mis");
    beat_q.push_back('{1'b0, 32'h6000, 4'b0010, 32'h0});
    rd_q.push_back(32'h00008000);
    issue(0, 0, 2'd0, 1, 32'h6001, 32'h0, 1, 0, 32'hFFFFFF80, 2);
    wait_done("lb");

    // split store
    beat_q.push_back('{1'b1, 32'h7000, 4'b1100, 32'h33440000});
    beat_q.push_back('{1'b1, 32'h7004, 4'b0011, 32'h00001122});
    issue(0, 1, 2'd2, 0, 32'h7002, 32'h11223344, 1, 0, 32'h0, 3);
    wait_done("sw_split");

    // 3-cycle stall in BEAT0: monitor re-checks the beat every stalled cycle
    stall_cnt = 3;
    beat_q.push_back('{1'b1, 32'h4000, 4'b1111, 32'hCAFEBABE});
    issue(0, 1, 2'd2, 0, 32'h4000, 32'hCAFEBABE, 1, 0, 32'h0, 5);
    wait_done("sw_stall");

    // reset during BEAT1 of a split store
    beat_q.push_back('{1'b1, 32'h8000, 4'b1100, 32'hC3D40000});
    beat_q.push_back('{1'b1, 32'h8004, 4'b0011, 32'h0000A1B2});
    issue(0, 1, 2'd2, 0, 32'h8002, 32'hA1B2C3D4, 0, 0, 32'h0, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus_valid0 && bus_addr0 == 32'h8004) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!found) fail_now("beat1_timeout");
    rst = 1'b1;
    #1;
    chk("async_bus_valid", bus_valid0, 1'b0);
    chk("async_bus_out", {bus_addr0, bus_be0, bus_wdata0}, 68'h0);
    chk("async_rsp", rsp_valid0, 1'b0);
    beat_q.delete();
    rd_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_req_ready", req_ready0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    beat_q.push_back('{1'b0, 32'h3000, 4'b1111, 32'h0});
    rd_q.push_back(32'h01020304);
    issue(0, 0, 2'd2, 0, 32'h3000, 32'h0, 1, 0, 32'h01020304, 2);
    wait_done("lw_after_rst");

    chk("bus1_never_valid", bus1_seen, 1'b0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store lane unit for the MEM stage. Supersedes the combinational byte-enable decoder.
- Takes one load/store request per transaction and drives an aligned data bus with byte enables.
- Splits accesses that cross a bus-word boundary into two bus beats, or flags them as errors, depending on a parameter.
- Returns load data already lane-extracted and sign- or zero-extended.

Parameters:
DW, 32, data bus width in bits; 32 or 64; NB = DW/8 byte lanes, OW = log2(NB).
AW, 32, address width.
SPLIT_EN, 1, 1: boundary-crossing access is split into two beats; 0: it completes with rsp_err.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 store, 0 load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword
req_signed  in  1  load sign-extension (1) or zero-extension (0)
req_addr  in  AW  byte address
req_wdata  in  DW  store data, right-justified
bus_valid  out  1  bus beat valid
bus_ready  in  1  beat accepted; for reads bus_rdata is valid in the same cycle
bus_we  out  1  beat is a write
bus_addr  out  AW  NB-aligned beat address
bus_be  out  NB  byte enables
bus_wdata  out  DW  lane-shifted store data
bus_rdata  in  DW  read data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DW  extended load result; 0 for stores and errors
rsp_err  out  1  access rejected, qualified by rsp_valid

Behaviour:
- Reset (asynchronous, active-high): state IDLE; req_ready=1; bus_valid, rsp_valid and rsp_err = 0; all data, address and be outputs = 0.
- Reset asserted mid-transaction abandons the transaction immediately. No response is produced. Captured beat data is cleared.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid, register the request; req_ready drops the next cycle.
  - Go to RESP with err=1 if S=8 and DW=32, or if the access crosses a boundary and SPLIT_EN=0.
  - Otherwise go to BEAT0.
- Definitions: S = 1<<req_size bytes; off = addr[OW-1:0]; cross = (off+S > NB).
- Masks and data:
  - M = ((1<<S)-1) << off, computed 2*NB bits wide.
  - W = req_wdata << (8*off), computed 2*DW bits wide.
- BEAT0: bus_valid=1, bus_addr = addr with low OW bits cleared, bus_be = M[NB-1:0], bus_wdata = W[DW-1:0], bus_we = req_we.
  - All bus outputs hold stable while bus_ready=0.
  - On bus_ready: capture bus_rdata into the low half of a 2*DW buffer. Go to BEAT1 if cross, else RESP.
- BEAT1: bus_addr = beat0 address + NB (wraps modulo 2^AW), bus_be = M[2NB-1:NB], bus_wdata = W[2DW-1:DW].
  - On bus_ready: capture bus_rdata into the high half and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Load result: buffer >> (8*off), lowest S bytes kept, then sign- or zero-extended to DW per req_signed.
  - If S = NB, no extension is applied.
- Misalignment that stays within one bus word (e.g. half at off=1) is legal: single beat, be=0110.
- bus_valid is 0 in IDLE and RESP.
- Latency:
  - Single beat, bus_ready=1: request cycle, then BEAT0, then RESP, so rsp_valid comes 2 cycles after acceptance.
  - Split: 3 cycles.
  - Error: 1 cycle.
- A new request is accepted in IDLE only. There is no overlap with RESP.

Test Plan:
- DW=32, sb addr 0x1003 wdata 0x000000AB -> single beat, bus_addr 0x1000, be 1000, bus_wdata 0xAB000000. rsp_valid 2 cycles after acceptance, rsp_rdata 0.
- lh signed addr 0x2002, bus_rdata 0x80011234 -> be 1100, rsp_rdata 0xFFFF8001. Same access as lhu -> 0x00008001.
- SPLIT_EN=1, lw addr 0x3003, beat0 rdata 0xDD000000, beat1 rdata 0x00CCBBAA -> beat0 0x3000/be 1000, beat1 0x3004/be 0111, rsp_rdata 0xCCBBAADD.
- SPLIT_EN=0, same lw 0x3003 -> bus_valid never asserted, rsp_valid with rsp_err=1 one cycle after acceptance. DW=32 with req_size=3 -> rsp_err=1.
- bus_ready held low 3 cycles in BEAT0, then high -> bus_addr, bus_be and bus_wdata unchanged throughout, one response.
- rst pulsed during BEAT1 of a split store -> outputs zero asynchronously, no rsp_valid, req_ready=1 after release. Next request completes normally.
